mips_multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and writeback. It drives the datapath mux selects, register and memory enables, and the 2-bit alu_op consumed directly by the downstream ALU control decoder. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/mips_pkg.sv | 76 +++++++
 rtl/mips_ctrl_outdec.sv | 85 ++++++++
 rtl/mips_multicycle_control.sv | 94 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants, state type and control bundle for the multicycle MIPS control.
// MIPS_CTRL_ADDI_EN adds addi decode; without it addi is treated as illegal.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  // S_FETCH as the decode result marks an unsupported opcode.
  function automatic state_t op_next(input logic [5:0] op);
    state_t s;
    s = S_FETCH;
    case (op)
      OP_RTYPE:     s = S_EXEC;
      OP_LW, OP_SW: s = S_MEMADR;
      OP_BEQ:       s = S_BRANCH;
      OP_J:         s = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
      OP_ADDI:      s = S_ADDI_EX;
`endif
      default:      s = S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational decode of FSM state (plus mem_ready/opcode) to datapath controls.
// MIPS_CTRL_ADDI_EN enables the addi execute/writeback states.
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b  = SRCB_IMMSH;
        o_ctrl.alu_op     = ALUOP_ADD;
        o_ctrl.illegal_op = (op_next(i_opcode) == S_FETCH);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.i_or_d     = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: state register, opcode latch, reset hold.
// MIPS_CTRL_ADDI_EN adds the addi sequence (decode -> addi_ex -> addi_wb).
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int RESET_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       instr_done
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [5:0] r_opcode;
  ctrl_t      w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RESET;
      r_cnt    <= '0;
      r_opcode <= '0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_cnt == HOLD_LAST) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_opcode <= opcode;
          r_state  <= op_next(opcode);
        end
        // Load/store split uses the opcode latched in decode.
        S_MEMADR: r_state <= (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_RWB;
        S_MEMWB, S_RWB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
        S_ADDI_EX: r_state <= S_ADDI_WB;
        S_ADDI_WB: r_state <= S_FETCH;
`endif
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_opcode    (opcode),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign illegal_op    = w_ctrl.illegal_op;
  assign instr_done    = w_ctrl.instr_done;

endmodule
